// File: rtl/flag_read_unit_pkg.sv
// Shared definitions for the flag read path: FSM states, Op/Cond encodings,
// flag bit indices in the 6-bit {S,Z,H,PV,N,C} vector and F byte positions.
package flag_read_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StEval,
    StHold
  } state_e;

  // Op encodings
  localparam logic [1:0] OpPackMain   = 2'b00;
  localparam logic [1:0] OpCond       = 2'b01;
  localparam logic [1:0] OpPackShadow = 2'b10;
  localparam logic [1:0] OpRsvd       = 2'b11;

  // Condition codes; bit 0 set means "flag set" test
  localparam logic [2:0] CondNz = 3'd0;
  localparam logic [2:0] CondZ  = 3'd1;
  localparam logic [2:0] CondNc = 3'd2;
  localparam logic [2:0] CondC  = 3'd3;
  localparam logic [2:0] CondPo = 3'd4;
  localparam logic [2:0] CondPe = 3'd5;
  localparam logic [2:0] CondP  = 3'd6;
  localparam logic [2:0] CondM  = 3'd7;

  // Bit indices within the 6-bit flag vector
  localparam int unsigned FlagC  = 0;
  localparam int unsigned FlagN  = 1;
  localparam int unsigned FlagPv = 2;
  localparam int unsigned FlagH  = 3;
  localparam int unsigned FlagZ  = 4;
  localparam int unsigned FlagS  = 5;

  // Bit positions within the packed F byte; bits 5 and 3 read as zero
  localparam int unsigned FByteC  = 0;
  localparam int unsigned FByteN  = 1;
  localparam int unsigned FBytePv = 2;
  localparam int unsigned FByteH  = 4;
  localparam int unsigned FByteZ  = 6;
  localparam int unsigned FByteS  = 7;

  function automatic logic [7:0] pack_f(input logic [5:0] flags);
    logic [7:0] f;
    f          = 8'h00;
    f[FByteS]  = flags[FlagS];
    f[FByteZ]  = flags[FlagZ];
    f[FByteH]  = flags[FlagH];
    f[FBytePv] = flags[FlagPv];
    f[FByteN]  = flags[FlagN];
    f[FByteC]  = flags[FlagC];
    return f;
  endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition-code evaluator over a 6-bit flag vector.
// Shared with the microsequencer branch logic.
module flag_cond_eval
  import flag_read_unit_pkg::*;
(
  input  logic [5:0] flags,
  input  logic [2:0] cond,
  output logic       result
);

  logic sel;

  // Cond[2:1] picks the flag, Cond[0] picks the tested polarity
  always_comb begin
    sel = 1'b0;
    unique case (cond)
      CondNz, CondZ: sel = flags[FlagZ];
      CondNc, CondC: sel = flags[FlagC];
      CondPo, CondPe: sel = flags[FlagPv];
      CondP, CondM:  sel = flags[FlagS];
      default:       sel = 1'b0;
    endcase
    result = cond[0] ? sel : ~sel;
  end

  // H and N never participate in a branch condition
  logic unused_flags;
  assign unused_flags = flags[FlagH] ^ flags[FlagN];

endmodule

// File: rtl/flag_read_unit.sv
// Flag read unit: snapshots F flags once no flag write is in flight, then
// packs them into an F byte or evaluates a branch condition.
// Build option: FLAG_READ_SHADOW_EN makes Op=10 read the shadow bank;
// without it Op=10 reads the main bank and FShadow is ignored.
module flag_read_unit
  import flag_read_unit_pkg::*;
#(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req,
  input  logic [1:0] Op,
  input  logic [2:0] Cond,
  input  logic       FlagWrBusy,
  input  logic [5:0] FMain,
  input  logic [5:0] FShadow,
  input  logic       Ack,
  output logic       Busy,
  output logic       Valid,
  output logic [7:0] Data,
  output logic       CondTrue,
  output logic       Stale
);

  localparam logic [3:0] StallMax = 4'(STALL_MAX);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] cond_q, cond_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] snap_q, snap_d;
  logic       snap_stale_q, snap_stale_d;
  logic [7:0] data_q, data_d;
  logic       cond_true_q, cond_true_d;
  logic       stale_q, stale_d;
  logic       valid_q, valid_d;

  logic       op_is_cond;
  logic       op_is_shadow;
  logic [5:0] bank;
  logic       eval_res;

  // Decode the latched operation; reserved Op behaves as pack-main
  always_comb begin
    op_is_cond   = 1'b0;
    op_is_shadow = 1'b0;
    unique case (op_q)
      OpPackMain, OpRsvd: ;
      OpCond:             op_is_cond = 1'b1;
      OpPackShadow:       op_is_shadow = 1'b1;
      default: ;
    endcase
  end

`ifdef FLAG_READ_SHADOW_EN
  assign bank = op_is_shadow ? FShadow : FMain;
`else
  assign bank = FMain;
  logic unused_shadow;
  assign unused_shadow = ^{FShadow, op_is_shadow};
`endif

  flag_cond_eval u_cond_eval (
    .flags  (snap_q),
    .cond   (cond_q),
    .result (eval_res)
  );

  // State and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      op_q         <= OpPackMain;
      cond_q       <= CondNz;
      cnt_q        <= 4'd0;
      snap_q       <= 6'd0;
      snap_stale_q <= 1'b0;
      data_q       <= 8'h00;
      cond_true_q  <= 1'b0;
      stale_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cond_q       <= cond_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      snap_stale_q <= snap_stale_d;
      data_q       <= data_d;
      cond_true_q  <= cond_true_d;
      stale_q      <= stale_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state logic: request latch, stall wait, evaluate, hold until Ack
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cond_d       = cond_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    snap_stale_d = snap_stale_q;
    data_d       = data_q;
    cond_true_d  = cond_true_q;
    stale_d      = stale_q;
    valid_d      = valid_q;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          op_d    = Op;
          cond_d  = Cond;
          cnt_d   = 4'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A write ending in the timeout cycle still counts as a clean capture
        if (!FlagWrBusy) begin
          snap_d       = bank;
          snap_stale_d = 1'b0;
          state_d      = StEval;
        end else if (cnt_q == StallMax) begin
          snap_d       = bank;
          snap_stale_d = 1'b1;
          state_d      = StEval;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StEval: begin
        data_d      = pack_f(snap_q);
        cond_true_d = op_is_cond & eval_res;
        stale_d     = snap_stale_q;
        valid_d     = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (Ack) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign Busy     = (state_q != StIdle);
  assign Valid    = valid_q;
  assign Data     = data_q;
  assign CondTrue = cond_true_q;
  assign Stale    = stale_q;

endmodule

// File: doc/flag_read_unit.md
# flag_read_unit

Read-side counterpart of the flag register write path. It snapshots the live F flags (main bank, and optionally the shadow bank) on request. It then either packs them into an 8-bit F byte for PUSH AF / LD A,F, or evaluates a 3-bit condition code for conditional jump, call and return. It sits between the flag registers and the microsequencer, and it stalls capture while any flag write is in flight so that consumers always see post-write values.

## Interface
Parameters:
- STALL_MAX, 15: maximum cycles spent waiting on FlagWrBusy before a forced capture (4-bit counter, range 1..15).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  request pulse; sampled only in IDLE
- Op  in  2  00 = pack main F, 01 = evaluate condition on main F, 10 = pack shadow F, 11 = reserved (treated as 00)
- Cond  in  3  condition code, valid with Req when Op=01: 0 NZ, 1 Z, 2 NC, 3 C, 4 PO, 5 PE, 6 P, 7 M
- FlagWrBusy  in  1  high in any cycle where PF_Write_*, PR_Write or PR_Ex is active
- FMain  in  6  live main flags {S,Z,H,PV,N,C}
- FShadow  in  6  live shadow flags, same order
- Ack  in  1  consumer accepts the result
- Busy  out  1  high in every state except IDLE
- Valid  out  1  result available
- Data  out  8  packed F byte {S,Z,0,H,0,PV,N,C}
- CondTrue  out  1  condition result (Op=01 only, else 0)
- Stale  out  1  result was force-captured after a stall timeout

## Operation
- FSM states: IDLE, WAIT, EVAL, HOLD.
- IDLE: when Req=1, latch Op and Cond. Go to WAIT.
- WAIT:
  - if FlagWrBusy=0: capture the selected bank into a 6-bit snapshot, Stale=0, go to EVAL.
  - else: increment the stall counter. When the counter reaches STALL_MAX, capture anyway, set Stale=1, go to EVAL.
- EVAL: compute Data and CondTrue from the snapshot into output registers. Valid=1 next. Go to HOLD.
- HOLD: Valid=1, and Data, CondTrue and Stale are held stable. On Ack=1, go to IDLE with Valid=0 next cycle.
- Op=01: Data = packed main F and CondTrue = evaluated condition.
- Op=00, 10 or 11: CondTrue=0.
- Condition decode uses snapshot bit Z, C, PV or S, selected by Cond[2:1]. Cond[0]=1 tests set, Cond[0]=0 tests clear.
- Req outside IDLE is ignored, with no queuing.
- Ack outside HOLD is ignored.
- Reset, including reset mid-operation, gives IDLE with Busy=0, Valid=0, Data=8'h00, CondTrue=0, Stale=0, stall counter 0, and the snapshot cleared.
- Stall counter clears on entry to WAIT.

## Timing
- Req at edge t, no write busy:
  - capture at t+1
  - Valid=1 after edge t+2
  - minimum latency 2 cycles
- Each FlagWrBusy cycle in WAIT adds 1 cycle, up to STALL_MAX.
- Ack sampled at the edge where Valid=1 gives Valid=0 and Busy=0 after that edge. The next Req is accepted at the following edge, so back-to-back throughput is one request per 4 cycles.
- FlagWrBusy falling in the same cycle the counter hits STALL_MAX is a normal capture (Stale=0).
- PR_Ex reported via FlagWrBusy delays capture, so a shadow read never observes a half-swapped bank.

## Configuration
- FLAG_READ_SHADOW_EN defined: Op=10 reads FShadow.
- FLAG_READ_SHADOW_EN undefined:
  - the FShadow port remains but is unused
  - Op=10 behaves exactly as Op=00 (main bank)
  - no shadow mux is synthesised

## Structure
- Shared package holds:
  - state enum {IDLE, WAIT, EVAL, HOLD}
  - Op encodings
  - Cond encodings
  - flag bit indices within the 6-bit vector
  - F byte bit positions
- One natural sub-module: flag_cond_eval, combinational, taking a 6-bit flag vector and Cond and returning a 1-bit result. It is reused by the microsequencer branch logic.

## Test plan
- Reset mid-HOLD with Valid=1 and Data=8'hC3 -> next cycle all outputs 0, Busy=0.
- FMain={1,1,0,0,0,1}, Req with Op=00 and FlagWrBusy=0 -> Valid 2 cycles later, Data=8'hC1, CondTrue=0; Ack -> Busy=0.
- Op=01, Cond=3 (C), FMain.C=1 -> CondTrue=1; repeat with Cond=2 -> CondTrue=0; Cond=7 with S=1 -> 1.
- FlagWrBusy high 3 cycles after Req, FMain changing C 0->1 during the stall -> Valid at t+5, Data[0]=1, Stale=0.
- FlagWrBusy held high, STALL_MAX=15 -> Valid at t+17, Stale=1.
- Op=10, FShadow=6'b000001, FMain=0 -> Data=8'h01 with FLAG_READ_SHADOW_EN, 8'h00 without; Req during HOLD ignored.
